// File: rtl/pcie_cpld_splitter.sv
// Completion splitter: turns one decoded Memory Read request into a train of
// CplD header descriptors. Each completion is limited by Max_Payload_Size,
// and the first completion also ends on a Read Completion Boundary.
module pcie_cpld_splitter #(
    parameter int unsigned  MPS_BYTES    = 256,
    parameter int unsigned  RCB_BYTES    = 64,
    parameter logic [15:0]  COMPLETER_ID = 16'h0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic [9:0]  req_length,
    input  logic [3:0]  req_first_be,
    input  logic [3:0]  req_last_be,
    input  logic [9:0]  req_tag,
    input  logic [15:0] req_requester_id,
    input  logic [2:0]  req_tc,
    input  logic [2:0]  req_attr,
    output logic        cpl_valid,
    input  logic        cpl_ready,
    output logic [95:0] cpl_hdr,
    output logic [10:0] cpl_len_dw,
    output logic        cpl_last
);

    localparam logic [10:0] MPS_DW   = 11'(MPS_BYTES / 4);
    localparam logic [10:0] RCB_MASK = 11'(RCB_BYTES / 4 - 1);

    // 3DW CplD header, DW0 in the most significant bits
    typedef struct packed {
        logic [2:0]  fmt;
        logic [4:0]  tlp_type;
        logic        tag9;
        logic [2:0]  tc;
        logic        tag8;
        logic        attr_ido;
        logic        ln;
        logic        th;
        logic        td;
        logic        ep;
        logic [1:0]  attr_lo;
        logic [1:0]  at;
        logic [9:0]  length;
        logic [15:0] completer_id;
        logic [2:0]  cpl_status;
        logic        bcm;
        logic [11:0] byte_cnt;
        logic [15:0] requester_id;
        logic [7:0]  tag_lo;
        logic        rsvd;
        logic [6:0]  lower_addr;
    } tlp_cpl_hdr_t;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state;
    logic [10:0] rem_dw;
    logic [10:0] cur_adw;
    logic [12:0] byte_rem;
    logic        first;
    logic [1:0]  off;
    logic [9:0]  tag;
    logic [15:0] requester_id;
    logic [2:0]  tc;
    logic [2:0]  attr;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[63:13], req_addr[1:0]};

    function automatic logic [1:0] low_idx(input logic [3:0] be);
        if (be[0])      return 2'd0;
        else if (be[1]) return 2'd1;
        else if (be[2]) return 2'd2;
        else if (be[3]) return 2'd3;
        else            return 2'd0;
    endfunction

    function automatic logic [1:0] high_idx(input logic [3:0] be);
        if (be[3])      return 2'd3;
        else if (be[2]) return 2'd2;
        else if (be[1]) return 2'd1;
        else            return 2'd0;
    endfunction

    // Request-derived starting values
    logic [10:0] a_rem;
    logic [1:0]  a_low;
    logic [12:0] a_bytes;
    // Values after the current completion is handed off
    logic [12:0] carried;
    logic [10:0] h_rem;
    logic [10:0] h_adw;
    logic [12:0] h_bytes;
    // Selected source for the next descriptor to present
    logic [10:0] s_rem;
    logic [10:0] s_adw;
    logic [12:0] s_bytes;
    logic        s_first;
    logic [1:0]  s_off;
    logic [10:0] base_n;
    logic [10:0] nxt_n;
    logic        nxt_last;
    tlp_cpl_hdr_t nxt_hdr;

    // Next-descriptor computation: from the incoming request in IDLE,
    // from the post-handshake counters in EMIT
    always_comb begin
        a_rem   = (req_length == 10'd0) ? 11'd1024 : {1'b0, req_length};
        a_low   = low_idx(req_first_be);
        if (req_length == 10'd1) begin
            if (req_first_be == 4'd0)
                a_bytes = 13'd1;
            else
                a_bytes = 13'(high_idx(req_first_be)) - 13'(a_low) + 13'd1;
        end else begin
            a_bytes = {a_rem, 2'b00} - 13'(a_low) - (13'd3 - 13'(high_idx(req_last_be)));
        end

        carried = {cpl_len_dw, 2'b00} - (first ? 13'(off) : 13'd0);
        h_rem   = rem_dw - cpl_len_dw;
        h_adw   = cur_adw + cpl_len_dw;
        h_bytes = byte_rem - carried;

        if (state == IDLE) begin
            s_rem   = a_rem;
            s_adw   = req_addr[12:2];
            s_bytes = a_bytes;
            s_first = 1'b1;
            s_off   = a_low;
        end else begin
            s_rem   = h_rem;
            s_adw   = h_adw;
            s_bytes = h_bytes;
            s_first = 1'b0;
            s_off   = 2'b00;
        end

        base_n   = s_first ? (MPS_DW - (s_adw & RCB_MASK)) : MPS_DW;
        nxt_last = (s_rem <= base_n);
        nxt_n    = nxt_last ? s_rem : base_n;

        nxt_hdr              = '0;
        nxt_hdr.fmt          = 3'b010;
        nxt_hdr.tlp_type     = 5'b01010;
        nxt_hdr.length       = nxt_n[9:0];
        nxt_hdr.completer_id = COMPLETER_ID;
        nxt_hdr.byte_cnt     = s_bytes[11:0];
        nxt_hdr.lower_addr   = {s_adw[4:0], s_off};
        if (state == IDLE) begin
            nxt_hdr.tag9         = req_tag[9];
            nxt_hdr.tag8         = req_tag[8];
            nxt_hdr.tag_lo       = req_tag[7:0];
            nxt_hdr.tc           = req_tc;
            nxt_hdr.attr_ido     = req_attr[2];
            nxt_hdr.attr_lo      = req_attr[1:0];
            nxt_hdr.requester_id = req_requester_id;
        end else begin
            nxt_hdr.tag9         = tag[9];
            nxt_hdr.tag8         = tag[8];
            nxt_hdr.tag_lo       = tag[7:0];
            nxt_hdr.tc           = tc;
            nxt_hdr.attr_ido     = attr[2];
            nxt_hdr.attr_lo      = attr[1:0];
            nxt_hdr.requester_id = requester_id;
        end
    end

    // Control FSM with registered descriptor outputs and split counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            cpl_valid    <= 1'b0;
            cpl_last     <= 1'b0;
            cpl_len_dw   <= '0;
            cpl_hdr      <= '0;
            rem_dw       <= '0;
            cur_adw      <= '0;
            byte_rem     <= '0;
            first        <= 1'b0;
            off          <= '0;
            tag          <= '0;
            requester_id <= '0;
            tc           <= '0;
            attr         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state        <= EMIT;
                        req_ready    <= 1'b0;
                        cpl_valid    <= 1'b1;
                        cpl_last     <= nxt_last;
                        cpl_len_dw   <= nxt_n;
                        cpl_hdr      <= nxt_hdr;
                        rem_dw       <= a_rem;
                        cur_adw      <= req_addr[12:2];
                        byte_rem     <= a_bytes;
                        first        <= 1'b1;
                        off          <= a_low;
                        tag          <= req_tag;
                        requester_id <= req_requester_id;
                        tc           <= req_tc;
                        attr         <= req_attr;
                    end
                end
                EMIT: begin
                    if (cpl_ready) begin
                        rem_dw   <= h_rem;
                        cur_adw  <= h_adw;
                        byte_rem <= h_bytes;
                        first    <= 1'b0;
                        if (cpl_last) begin
                            state     <= IDLE;
                            req_ready <= 1'b1;
                            cpl_valid <= 1'b0;
                            cpl_last  <= 1'b0;
                        end else begin
                            cpl_last   <= nxt_last;
                            cpl_len_dw <= nxt_n;
                            cpl_hdr    <= nxt_hdr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_cpld_splitter.sv
// Scoreboard bench for pcie_cpld_splitter: directed requests push the
// hand-computed completion headers; a monitor pops and compares on handshake.
module tb_pcie_cpld_splitter;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [9:0]  req_length;
    logic [3:0]  req_first_be;
    logic [3:0]  req_last_be;
    logic [9:0]  req_tag;
    logic [15:0] req_requester_id;
    logic [2:0]  req_tc;
    logic [2:0]  req_attr;
    logic        cpl_valid;
    logic        cpl_ready;
    logic [95:0] cpl_hdr;
    logic [10:0] cpl_len_dw;
    logic        cpl_last;

    pcie_cpld_splitter #(
        .MPS_BYTES(256),
        .RCB_BYTES(64),
        .COMPLETER_ID(16'h0100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .req_length(req_length),
        .req_first_be(req_first_be),
        .req_last_be(req_last_be),
        .req_tag(req_tag),
        .req_requester_id(req_requester_id),
        .req_tc(req_tc),
        .req_attr(req_attr),
        .cpl_valid(cpl_valid),
        .cpl_ready(cpl_ready),
        .cpl_hdr(cpl_hdr),
        .cpl_len_dw(cpl_len_dw),
        .cpl_last(cpl_last)
    );

    typedef struct {
        logic [95:0] hdr;
        logic [10:0] len;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    int unsigned vectors;
    int unsigned miscompares;
    logic        stall_mode;
    int unsigned stall_cnt;
    logic        mon_en;
    logic        stalled_prev;
    logic [95:0] held_hdr;
    logic [10:0] held_len;
    logic        held_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] mk_hdr(input logic [10:0] len, input logic [11:0] bc,
                                           input logic [6:0] la, input logic [9:0] tg,
                                           input logic [15:0] rid, input logic [2:0] t,
                                           input logic [2:0] at);
        return {3'b010, 5'b01010, tg[9], t, tg[8], at[2], 4'b0000, at[1:0], 2'b00, len[9:0],
                16'h0100, 3'b000, 1'b0, bc,
                rid, tg[7:0], 1'b0, la};
    endfunction

    task automatic push(input logic [10:0] len, input logic [11:0] bc, input logic [6:0] la,
                        input logic last);
        exp_t e;
        e.hdr  = mk_hdr(len, bc, la, req_tag, req_requester_id, req_tc, req_attr);
        e.len  = len;
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic set_req(input logic [63:0] a, input logic [9:0] l, input logic [3:0] fbe,
                           input logic [3:0] lbe, input logic [9:0] tg, input logic [15:0] rid,
                           input logic [2:0] t, input logic [2:0] at);
        req_addr = a; req_length = l; req_first_be = fbe; req_last_be = lbe;
        req_tag = tg; req_requester_id = rid; req_tc = t; req_attr = at;
    endtask

    task automatic send;
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            vectors++; miscompares++;
            $display("FAIL req_ready_timeout: got 0, expected 1");
        end
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done;
        int unsigned n;
        n = 0;
        while ((sb.size() != 0 || cpl_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (sb.size() != 0 || cpl_valid) begin
            miscompares++;
            $display("FAIL drain_timeout: pending %0d, expected 0", sb.size());
        end
    endtask

    // Downstream ready: always 1, or 5 stalled cycles per descriptor in stall mode
    initial begin
        cpl_ready = 1'b1;
        stall_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!stall_mode) begin
                cpl_ready = 1'b1;
            end else if (cpl_valid && stall_cnt < 5) begin
                cpl_ready = 1'b0;
                stall_cnt++;
            end else begin
                cpl_ready = 1'b1;
                stall_cnt = 0;
            end
        end
    end

    // Monitor: compare on handshake, check stability while stalled
    initial begin
        stalled_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && cpl_valid) begin
                check("req_ready_in_emit", {95'd0, req_ready}, 96'd0);
                if (!cpl_ready) begin
                    if (stalled_prev) begin
                        check("stall_hdr", cpl_hdr, held_hdr);
                        check("stall_len", {85'd0, cpl_len_dw}, {85'd0, held_len});
                        check("stall_last", {95'd0, cpl_last}, {95'd0, held_last});
                    end
                    stalled_prev = 1'b1;
                    held_hdr  = cpl_hdr;
                    held_len  = cpl_len_dw;
                    held_last = cpl_last;
                end else begin
                    stalled_prev = 1'b0;
                    if (sb.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL unexpected_cpl: got hdr %h, expected none", cpl_hdr);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("cpl_hdr", cpl_hdr, e.hdr);
                        check("cpl_len_dw", {85'd0, cpl_len_dw}, {85'd0, e.len});
                        check("cpl_last", {95'd0, cpl_last}, {95'd0, e.last});
                    end
                end
            end else begin
                stalled_prev = 1'b0;
            end
        end
    end

    task automatic scen2(input logic [9:0] tg);
        set_req(64'h1010, 10'd128, 4'hF, 4'hF, tg, 16'hBEEF, 3'd5, 3'b101);
        push(11'd60, 12'd512, 7'h10, 1'b0);
        push(11'd64, 12'd272, 7'h00, 1'b0);
        push(11'd4,  12'd16,  7'h00, 1'b1);
        send();
        wait_done();
    endtask

    initial begin
        int unsigned n;
        vectors = 0; miscompares = 0;
        stall_mode = 1'b0; mon_en = 1'b1;
        req_valid = 1'b0;
        set_req(64'h0, 10'd0, 4'h0, 4'h0, 10'd0, 16'd0, 3'd0, 3'd0);
        rst_n = 1'b0;
        #23;
        check("rst_req_ready", {95'd0, req_ready}, 96'd1);
        check("rst_cpl_valid", {95'd0, cpl_valid}, 96'd0);
        check("rst_cpl_last", {95'd0, cpl_last}, 96'd0);
        check("rst_cpl_len", {85'd0, cpl_len_dw}, 96'd0);
        check("rst_cpl_hdr", cpl_hdr, 96'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single completion
        set_req(64'h1000, 10'd4, 4'hF, 4'hF, 10'h003, 16'h1234, 3'd0, 3'b000);
        push(11'd4, 12'd16, 7'h00, 1'b1);
        send();
        wait_done();

        // 2: RCB-aligned split
        scen2(10'h2A5);

        // 3: single DW with partial / empty byte enables
        set_req(64'h2004, 10'd1, 4'b0100, 4'h0, 10'h155, 16'h0A0B, 3'd7, 3'b010);
        push(11'd1, 12'd1, 7'h06, 1'b1);
        send();
        wait_done();
        set_req(64'h2004, 10'd1, 4'b0000, 4'h0, 10'h156, 16'h0A0B, 3'd1, 3'b001);
        push(11'd1, 12'd1, 7'h04, 1'b1);
        send();
        wait_done();

        // 4: 1024 DW request, 16 completions
        set_req(64'h0, 10'd0, 4'hF, 4'hF, 10'h3FF, 16'hFFFF, 3'd2, 3'b100);
        for (int i = 0; i < 16; i++)
            push(11'd64, 12'(4096 - 256 * i), 7'h00, i == 15);
        send();
        wait_done();

        // 5: scenario 2 with downstream stalls
        stall_mode = 1'b1;
        scen2(10'h0C3);
        stall_mode = 1'b0;
        @(negedge clk);

        // 6: reset after first completion of scenario 2
        set_req(64'h1010, 10'd128, 4'hF, 4'hF, 10'h011, 16'hBEEF, 3'd5, 3'b101);
        push(11'd60, 12'd512, 7'h10, 1'b0);
        send();
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scen6_first_seen", {95'd0, sb.size() == 0}, 96'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst6_cpl_valid", {95'd0, cpl_valid}, 96'd0);
        check("rst6_cpl_hdr", cpl_hdr, 96'd0);
        check("rst6_cpl_len", {85'd0, cpl_len_dw}, 96'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst6_req_ready", {95'd0, req_ready}, 96'd1);
        check("rst6_idle_valid", {95'd0, cpl_valid}, 96'd0);
        set_req(64'h3000, 10'd4, 4'hF, 4'hF, 10'h022, 16'h4321, 3'd3, 3'b011);
        push(11'd4, 12'd16, 7'h00, 1'b1);
        send();
        wait_done();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
